// File: rtl/onehot_capture.sv
// onehot_capture: debounced one-hot request capture with ack handshake; ONEHOT_CAPTURE_PRIORITY_EN resolves multi-bit captures to the lowest set bit instead of raising Err.
module onehot_capture #(
  parameter int DB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] Req,
  input  logic       Ack,
  output logic [7:0] Data,
  output logic       Valid,
  output logic       Err
);
  localparam logic [1:0] IDLE = 2'd0, DEBOUNCE = 2'd1, HOLD = 2'd2, WAIT_REL = 2'd3;
  localparam logic [7:0] CNT_MAX = 8'(DB_CYCLES - 1);
  logic [1:0] state_q, state_d;
  logic [7:0] s1_q, s2_q, snap_q, snap_d, cnt_q, cnt_d, data_q, data_d;
  logic       valid_q, valid_d, err_q, err_d, onehot;
  assign onehot = (snap_q & (snap_q - 8'd1)) == 8'd0;
`ifdef ONEHOT_CAPTURE_PRIORITY_EN
  logic [7:0] low_bit;
  assign low_bit = snap_q & (~snap_q + 8'd1);
`endif
  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (s2_q != 8'd0) begin
        snap_d  = s2_q;
        cnt_d   = 8'd0;
        state_d = DEBOUNCE;
      end
      DEBOUNCE: if (s2_q == 8'd0) state_d = IDLE;
      else if (s2_q != snap_q) begin
        snap_d = s2_q;
        cnt_d  = 8'd0;
      end else if (cnt_q != CNT_MAX) cnt_d = cnt_q + 8'd1;
      else if (onehot) begin
        data_d  = snap_q;
        valid_d = 1'b1;
        state_d = HOLD;
      end else begin
`ifdef ONEHOT_CAPTURE_PRIORITY_EN
        data_d  = low_bit;
        valid_d = 1'b1;
        state_d = HOLD;
`else
        err_d   = 1'b1;
        state_d = WAIT_REL;
`endif
      end
      HOLD: if (Ack) begin
        data_d  = 8'd0;
        valid_d = 1'b0;
        state_d = WAIT_REL;
      end
      WAIT_REL: if (s2_q == 8'd0) state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s1_q    <= 8'd0;
      s2_q    <= 8'd0;
      snap_q  <= 8'd0;
      cnt_q   <= 8'd0;
      data_q  <= 8'd0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s1_q    <= Req;
      s2_q    <= s1_q;
      snap_q  <= snap_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end
  assign Data  = data_q;
  assign Valid = valid_q;
  assign Err   = err_q;
endmodule

// File: doc/onehot_capture.md
ONEHOT_CAPTURE -- requirements
Module: onehot_capture

Interface
REQ-001 The block SHALL have parameter DB_CYCLES, default 4, meaning the number of consecutive stable cycles required before capture (legal range 2..255).
REQ-002 The block SHALL have port clk, input, 1, the single rising-edge clock for all state.
REQ-003 The block SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-004 The block SHALL have port Req, input, 8, raw asynchronous request lines, one per source.
REQ-005 The block SHALL have port Ack, input, 1, a downstream acknowledge of the held Data.
REQ-006 The block SHALL have port Data, output, 8, a registered one-hot word for the downstream 8-to-3 encoder; all-zero when not holding.
REQ-007 The block SHALL have port Valid, output, 1, registered; high while Data holds a captured one-hot value.
REQ-008 The block SHALL have port Err, output, 1, registered; a one-cycle pulse on a rejected multi-bit capture.

Function
REQ-009 The block SHALL pass Req through a 2-flop synchronizer (s1, s2); all decisions SHALL use s2 only.
REQ-010 The block SHALL implement FSM states IDLE, DEBOUNCE, HOLD and WAIT_REL, with an 8-bit snapshot register and an 8-bit stability counter cnt.
REQ-011 IDLE: when s2 != 0, the block SHALL load snapshot=s2 and cnt=0, then enter DEBOUNCE; otherwise it SHALL stay in IDLE.
REQ-012 DEBOUNCE, s2 == 0: the block SHALL return to IDLE with no output change.
REQ-013 DEBOUNCE, s2 != snapshot and s2 != 0: the block SHALL reload snapshot=s2 and cnt=0, restarting the debounce.
REQ-014 DEBOUNCE, s2 == snapshot and cnt < DB_CYCLES-1: the block SHALL increment cnt.
REQ-015 DEBOUNCE, s2 == snapshot, cnt == DB_CYCLES-1, snapshot exactly one-hot: the block SHALL load Data=snapshot, set Valid=1 and enter HOLD.
REQ-016 DEBOUNCE, s2 == snapshot, cnt == DB_CYCLES-1, snapshot has more than one bit set: the block SHALL pulse Err for exactly one cycle, keep Data=0 and Valid=0, and enter WAIT_REL.
REQ-017 Latency: with Req stable before rising edge 1, Valid SHALL be high after edge DB_CYCLES+3 (edge 7 for the default).
REQ-018 HOLD: Data and Valid SHALL stay constant regardless of Req until an edge samples Ack=1; the block SHALL then clear Data to 0, clear Valid to 0 and enter WAIT_REL.
REQ-019 Ack sampled while Valid=0 SHALL be ignored.
REQ-020 WAIT_REL: the block SHALL stay until s2 == 0, then enter IDLE, so one press yields at most one capture.
REQ-021 Err and Valid SHALL never be high in the same cycle.
REQ-022 In every state other than HOLD, Data SHALL equal 8'h00.

Reset
REQ-023 rst=1 at a rising edge SHALL force state=IDLE, s1=s2=0, snapshot=0, cnt=0, Data=0, Valid=0 and Err=0, overriding any other event in that cycle, including mid-DEBOUNCE or mid-HOLD.
REQ-024 After rst deasserts, a Req held high throughout SHALL be treated as a new request with the full REQ-017 latency.

Configuration
REQ-025 The block SHALL use the macro ONEHOT_CAPTURE_PRIORITY_EN.
REQ-026 With ONEHOT_CAPTURE_PRIORITY_EN defined, a multi-bit snapshot at capture time SHALL NOT raise Err; instead Data SHALL be set to its lowest-index set bit alone, Valid=1, and the block SHALL enter HOLD.
REQ-027 Without ONEHOT_CAPTURE_PRIORITY_EN, the behaviour SHALL be as in REQ-016, and Err SHALL be the only multi-bit outcome.

Verification
REQ-028 Scenario: Req=8'h04 held, DB_CYCLES=4 -> Valid=1 and Data=8'h04 after edge 7; with Ack=1 for one cycle -> Valid=0 and Data=0 the next cycle; with Req still high -> no second capture.
REQ-029 Scenario: Req toggles 8'h10/8'h00 every 2 cycles for 20 cycles -> Valid stays 0 and Err stays 0.
REQ-030 Scenario: Req=8'h12 held -> macro off: Err pulses one cycle at edge 7 and Valid stays 0; macro on: Data=8'h02 and Valid=1 at edge 7.
REQ-031 Scenario: Req changes 8'h01 -> 8'h80 during DEBOUNCE -> counter restarts and Data=8'h80 is captured DB_CYCLES+1 edges after s2 changes.
REQ-032 Scenario: rst=1 for one cycle while in HOLD with Data=8'h20 -> the next cycle shows Data=0, Valid=0, Err=0, state IDLE; the held Req is then recaptured per REQ-024.
REQ-033 Scenario: Ack=1 held constantly while in IDLE and DEBOUNCE -> no effect until Valid rises; the capture is then consumed on the first HOLD edge.
